rwc_responder: RTL and testbench

//  Responder end of the challenge/response handshake driven by the PUF top controller.
//  - Takes a challenge (data, address) when gen_enable rises.
//  - Forces two read-write collisions on a dual-port BRAM, one per data polarity.
//  - Returns both read-back words as rsp_pos/rsp_neg and pulses available.
//  - BRAM primitive sits outside this block; this block only drives its port A (write)
//    and port B (read) signals.

---
 rtl/rwc_responder_if.sv | 33 +++
 rtl/rwc_responder.sv | 158 +++++++++++++++
 tb/tb_rwc_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rwc_responder_if.sv
// Bundle between the PUF top controller / BRAM and the RWC responder.
// The responder uses the slave modport; the controller side uses master.
interface rwc_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              gen_enable;
  logic [DATA_W-1:0] cha_data;
  logic [ADDR_W-1:0] cha_addr;
  logic              available;
  logic [DATA_W-1:0] rsp_pos;
  logic [DATA_W-1:0] rsp_neg;
  logic              busy;
  logic              bram_ena;
  logic              bram_wea;
  logic [ADDR_W-1:0] bram_addra;
  logic [DATA_W-1:0] bram_dina;
  logic              bram_enb;
  logic [ADDR_W-1:0] bram_addrb;
  logic [DATA_W-1:0] bram_doutb;

  modport master (
    output gen_enable, cha_data, cha_addr, bram_doutb,
    input  available, rsp_pos, rsp_neg, busy,
    input  bram_ena, bram_wea, bram_addra, bram_dina, bram_enb, bram_addrb
  );

  modport slave (
    input  gen_enable, cha_data, cha_addr, bram_doutb,
    output available, rsp_pos, rsp_neg, busy,
    output bram_ena, bram_wea, bram_addra, bram_dina, bram_enb, bram_addrb
  );
endinterface

// File: rtl/rwc_responder.sv
// Responder for the PUF challenge/response handshake: forces two read-write
// collisions on an external dual-port BRAM (one per data polarity) and returns both read-backs.
module rwc_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic           clk,
  input  logic           resetn,
  rwc_responder_if.slave bus
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE1, S_COL1, S_CAP1, S_PRE2, S_COL2, S_CAP2, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] pos_sh_q, pos_sh_d;
  logic              gen_q;
  logic              start;

  logic              ena_q, ena_d;
  logic              enb_q, enb_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [ADDR_W-1:0] addrb_q, addrb_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              avail_q, avail_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rsp_pos_q, rsp_pos_d;
  logic [DATA_W-1:0] rsp_neg_q, rsp_neg_d;

  assign start = (state_q == S_IDLE) && bus.gen_enable && !gen_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    addr_d   = addr_q;
    pos_sh_d = pos_sh_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRE1;
          data_d  = bus.cha_data;
          addr_d  = bus.cha_addr;
        end
      end
      S_PRE1: state_d = S_COL1;
      S_COL1: begin
        state_d = S_CAP1;
        cnt_d   = '0;
      end
      S_CAP1: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = S_PRE2;
          pos_sh_d = bus.bram_doutb;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PRE2: state_d = S_COL2;
      S_COL2: begin
        state_d = S_CAP2;
        cnt_d   = '0;
      end
      S_CAP2: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    ena_d   = (state_d == S_PRE1) || (state_d == S_COL1) ||
              (state_d == S_PRE2) || (state_d == S_COL2);
    enb_d   = (state_d == S_COL1) || (state_d == S_COL2);
    addra_d = ena_d ? addr_d : addra_q;
    addrb_d = enb_d ? addr_d : addrb_q;

    dina_d = dina_q;
    if ((state_d == S_PRE1) || (state_d == S_COL2)) begin
      dina_d = ~data_d;
    end else if ((state_d == S_COL1) || (state_d == S_PRE2)) begin
      dina_d = data_d;
    end

    avail_d   = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
    rsp_pos_d = rsp_pos_q;
    rsp_neg_d = rsp_neg_q;
    if (state_d == S_DONE) begin
      // The neg read-back is captured on the same edge that enters DONE.
      rsp_pos_d = pos_sh_q;
      rsp_neg_d = bus.bram_doutb;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      pos_sh_q  <= '0;
      gen_q     <= 1'b0;
      ena_q     <= 1'b0;
      enb_q     <= 1'b0;
      addra_q   <= '0;
      addrb_q   <= '0;
      dina_q    <= '0;
      avail_q   <= 1'b0;
      busy_q    <= 1'b0;
      rsp_pos_q <= '0;
      rsp_neg_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      pos_sh_q  <= pos_sh_d;
      gen_q     <= bus.gen_enable;
      ena_q     <= ena_d;
      enb_q     <= enb_d;
      addra_q   <= addra_d;
      addrb_q   <= addrb_d;
      dina_q    <= dina_d;
      avail_q   <= avail_d;
      busy_q    <= busy_d;
      rsp_pos_q <= rsp_pos_d;
      rsp_neg_q <= rsp_neg_d;
    end
  end

  assign bus.bram_ena   = ena_q;
  assign bus.bram_wea   = ena_q;
  assign bus.bram_addra = addra_q;
  assign bus.bram_dina  = dina_q;
  assign bus.bram_enb   = enb_q;
  assign bus.bram_addrb = addrb_q;
  assign bus.available  = avail_q;
  assign bus.busy       = busy_q;
  assign bus.rsp_pos    = rsp_pos_q;
  assign bus.rsp_neg    = rsp_neg_q;

endmodule

// File: tb/tb_rwc_responder.sv
// Bench for rwc_responder: three instances (RD_LAT 1, 2, 4), each with a behavioural BRAM
// whose collision behaviour is selectable read-first / write-first; results go through a scoreboard.
module tb_rwc_responder;

  localparam int DW = 32;
  localparam int AW = 10;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 4;
  endfunction

  typedef struct {
    int          inst;
    logic [31:0] pos;
    logic [31:0] neg;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  logic write_first;
  int   cyc = 0;

  logic [2:0]          gen_en;
  logic [DW-1:0]       cha_d;
  logic [AW-1:0]       cha_a;
  logic [2:0]          avail, busy, ena, wea, enb;
  logic [2:0][DW-1:0]  pos, neg, dina;
  logic [2:0][AW-1:0]  addra, addrb;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses[3];
  int   runs[3];
  int   spurious = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int L = lat_of(g);
    rwc_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    rwc_responder #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(L)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
    );

    logic [DW-1:0] mem  [1024];
    logic [DW-1:0] pipe [L];

    always @(posedge clk) begin
      if (bus.bram_ena && bus.bram_wea) mem[bus.bram_addra] <= bus.bram_dina;
      if (bus.bram_enb)
        pipe[0] <= (write_first && bus.bram_ena && bus.bram_wea &&
                    bus.bram_addra == bus.bram_addrb) ? bus.bram_dina : mem[bus.bram_addrb];
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end

    assign bus.bram_doutb = pipe[L-1];
    assign bus.gen_enable = gen_en[g];
    assign bus.cha_data   = cha_d;
    assign bus.cha_addr   = cha_a;
    assign avail[g] = bus.available;
    assign busy[g]  = bus.busy;
    assign ena[g]   = bus.bram_ena;
    assign wea[g]   = bus.bram_wea;
    assign enb[g]   = bus.bram_enb;
    assign pos[g]   = bus.rsp_pos;
    assign neg[g]   = bus.rsp_neg;
    assign dina[g]  = bus.bram_dina;
    assign addra[g] = bus.bram_addra;
    assign addrb[g] = bus.bram_addrb;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises gen_enable for one cycle (cycle 0) and returns at cycle 1.
  task automatic start_run(input int g, input logic [31:0] d, input logic [9:0] a, input bit push);
    exp_t e;
    cha_d = d;
    cha_a = a;
    gen_en[g] = 1'b1;
    if (push) begin
      e.inst = g;
      e.pos  = write_first ? d : ~d;
      e.neg  = write_first ? ~d : d;
      e.due  = cyc + 5 + 2 * lat_of(g);
      sb.push_back(e);
      runs[g]++;
    end
    tick();
    gen_en[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy[g]) && n < 100) begin
      tick();
      n++;
    end
    check("run_timeout", 64'(n < 100), 64'd1);
    if (n >= 100) sb.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (avail[g] === 1'b1) begin
        pulses[g]++;
        if (sb.size() > 0 && sb[0].inst == g) begin
          e = sb.pop_front();
          check($sformatf("rsp_pos_L%0d", lat_of(g)), 64'(pos[g]), 64'(e.pos));
          check($sformatf("rsp_neg_L%0d", lat_of(g)), 64'(neg[g]), 64'(e.neg));
          check($sformatf("avail_cycle_L%0d", lat_of(g)), 64'(cyc), 64'(e.due));
        end else begin
          spurious++;
        end
      end
    end
  end

  initial begin
    resetn = 1'b0;
    write_first = 1'b0;
    gen_en = '0;
    cha_d = '0;
    cha_a = '0;
    for (int g = 0; g < 3; g++) begin
      pulses[g] = 0;
      runs[g] = 0;
    end
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    for (int g = 0; g < 3; g++) begin
      check("rst_ctl", 64'({avail[g], busy[g], ena[g], wea[g], enb[g]}), 64'd0);
      check("rst_rsp", {pos[g], neg[g]}, 64'd0);
      check("rst_bus", 64'({addra[g], addrb[g], dina[g]}), 64'd0);
    end

    // Scenario 1 and 2: default latency, both collision models.
    start_run(1, 32'hFFFF_FFFF, 10'h000, 1'b1);
    wait_done(1);
    tick();
    write_first = 1'b1;
    start_run(1, 32'hFFFF_FFFF, 10'h000, 1'b1);
    wait_done(1);
    tick();
    write_first = 1'b0;

    // Scenario 3: port A/B sequence at the top address.
    start_run(1, 32'hA5A5_5A5A, 10'h3FF, 1'b1);
    check("seq1_en", 64'({ena[1], wea[1], enb[1]}), 64'b110);
    check("seq1_a", 64'({addra[1], dina[1]}), {22'd0, 10'h3FF, 32'h5A5A_A5A5});
    tick();
    check("seq2_en", 64'({ena[1], wea[1], enb[1]}), 64'b111);
    check("seq2_a", 64'({addra[1], dina[1]}), {22'd0, 10'h3FF, 32'hA5A5_5A5A});
    check("seq2_b", 64'(addrb[1]), 64'h3FF);
    tick();
    check("seq3_en", 64'({ena[1], wea[1], enb[1]}), 64'b000);
    tick();
    check("seq4_en", 64'({ena[1], wea[1], enb[1]}), 64'b000);
    tick();
    check("seq5_en", 64'({ena[1], wea[1], enb[1]}), 64'b110);
    check("seq5_a", 64'({addra[1], dina[1]}), {22'd0, 10'h3FF, 32'hA5A5_5A5A});
    wait_done(1);
    tick();

    // Scenario 4: held level, toggle while busy, toggle after DONE.
    start_run(1, 32'h1234_5678, 10'h055, 1'b1);
    gen_en[1] = 1'b1;
    repeat (30) tick();
    gen_en[1] = 1'b0;
    wait_done(1);
    repeat (2) tick();
    start_run(1, 32'h0F0F_00FF, 10'h123, 1'b1);
    repeat (2) tick();
    gen_en[1] = 1'b1;
    tick();
    gen_en[1] = 1'b0;
    wait_done(1);
    repeat (20) tick();
    start_run(1, 32'hCAFE_F00D, 10'h2AA, 1'b1);
    wait_done(1);
    tick();

    // Scenario 5: reset asserted in cycle 4 of a run.
    start_run(1, 32'hDEAD_BEEF, 10'h011, 1'b0);
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    check("rstmid_en", 64'({ena[1], wea[1], enb[1]}), 64'd0);
    check("rstmid_ctl", 64'({avail[1], busy[1]}), 64'd0);
    check("rstmid_rsp", {pos[1], neg[1]}, 64'd0);
    resetn = 1'b1;
    repeat (20) tick();

    // Scenario 6 plus random challenges on every latency and both models.
    start_run(0, 32'hFFFF_FFFF, 10'h000, 1'b1);
    wait_done(0);
    tick();
    start_run(2, 32'hFFFF_FFFF, 10'h000, 1'b1);
    wait_done(2);
    tick();
    for (int i = 0; i < 6; i++) begin
      write_first = i[0];
      start_run(i % 3, $urandom, 10'($urandom), 1'b1);
      wait_done(i % 3);
      tick();
    end

    repeat (10) tick();
    for (int g = 0; g < 3; g++) check($sformatf("pulse_count_L%0d", lat_of(g)), 64'(pulses[g]), 64'(runs[g]));
    check("spurious_avail", 64'(spurious), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
